// File: rtl/dmem_mmio_pkg.sv
// Shared decode constants and types for dmem_mmio_unit and its TX FIFO.
package dmem_mmio_pkg;

   // Word selects within the MMIO page, taken from address bits [4:2]
   localparam logic [2:0] OFF_LED    = 3'd0;
   localparam logic [2:0] OFF_CYCLE  = 3'd1;
   localparam logic [2:0] OFF_CMP    = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_TXDATA = 3'd4;

   localparam int unsigned STAT_MATCH = 0;
   localparam int unsigned STAT_FULL  = 1;
   localparam int unsigned STAT_EMPTY = 2;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_MMIO = 2'd1,
      REG_NONE = 2'd2
   } region_t;

   // RAM wins over the MMIO page if the two ever overlap
   function automatic region_t decode_region(input logic [31:0] addr,
                                             input logic [31:0] ram_bytes,
                                             input logic [19:0] page);
      region_t r;
      if (addr < ram_bytes) begin
         r = REG_RAM;
      end else if (addr[31:12] == page) begin
         r = REG_MMIO;
      end else begin
         r = REG_NONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_mmio_unit_tx_fifo.sv
// tx_fifo: circular byte FIFO with extra-bit pointers; a pop frees a slot for a
// same-cycle push when full, and the head reads 0 while empty.
module tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [WIDTH-1:0]              head
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] buf_r [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign count     = wr_ptr_r - rd_ptr_r;
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign head      = empty ? {WIDTH{1'b0}} : buf_r[rd_ptr_r[AW-1:0]];

   // Pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
      end
   end

   // Storage; never read while empty, so it needs no reset
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         buf_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/dmem_mmio_unit.sv
// dmem_mmio_unit: word RAM plus an MMIO page (LED, cycle counter, compare timer,
// console TX FIFO). Optional access-fault detection under macro DMEM_FAULT_EN.
module dmem_mmio_unit
   import dmem_mmio_pkg::*;
#(
   parameter int          DEPTH      = 64,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   output logic [31:0] ReadDataM,
   output logic [7:0]  led,
   output logic        timer_irq,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        fault
);

   localparam int          IW        = $clog2(DEPTH);
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

   logic [31:0] mem_r [DEPTH];
   logic [31:0] cycle_r;
   logic [31:0] cmp_r;
   logic [7:0]  led_r;
   logic        flag_r;

   region_t     region_s;
   logic [IW-1:0] idx_s;
   logic [2:0]  sel_s;
   logic        fault_s;
   logic        commit_s;
   logic        ram_we_s;
   logic        mmio_we_s;
   logic        match_s;
   logic        clr_s;
   logic        flag_next_s;
   logic        push_s;
   logic        pop_s;
   logic        full_s;
   logic        empty_s;
   logic [CW-1:0] count_s;
   logic [7:0]  head_s;
   logic [31:0] status_s;
   logic [31:0] rdata_s;

   assign region_s = decode_region(ALUResultM, RAM_BYTES, MMIO_BASE[31:12]);
   assign idx_s    = ALUResultM[IW+1:2];
   assign sel_s    = ALUResultM[4:2];

`ifdef DMEM_FAULT_EN
   logic misaligned_s;
   logic cyc_store_s;
   logic fault_r;

   // Every cycle counts as an access because loads are not flagged separately
   assign misaligned_s = (ALUResultM[1:0] != 2'b00);
   assign cyc_store_s  = MemWriteM && (region_s == REG_MMIO) && (sel_s == OFF_CYCLE);
   assign fault_s      = misaligned_s || (region_s == REG_NONE) || cyc_store_s;

   // One-cycle registered fault pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_r <= 1'b0;
      end else begin
         fault_r <= fault_s;
      end
   end

   assign fault = fault_r;
`else
   assign fault_s = 1'b0;
   assign fault   = 1'b0;
`endif

   assign commit_s  = MemWriteM && !fault_s;
   assign ram_we_s  = commit_s && (region_s == REG_RAM);
   assign mmio_we_s = commit_s && (region_s == REG_MMIO);
   assign push_s    = mmio_we_s && (sel_s == OFF_TXDATA);
   assign pop_s     = !empty_s && tx_ready;
   assign match_s   = (cycle_r == cmp_r) && (cmp_r != 32'd0);
   assign clr_s     = mmio_we_s && (sel_s == OFF_STATUS) && WriteDataM[STAT_MATCH];

   // Sticky match flag: a set on the same edge as a clear wins
   always_comb begin
      flag_next_s = flag_r;
      if (match_s) begin
         flag_next_s = 1'b1;
      end else if (clr_s) begin
         flag_next_s = 1'b0;
      end else begin
         flag_next_s = flag_r;
      end
   end

   // MMIO register file and free-running counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_r <= 32'd0;
         cmp_r   <= 32'd0;
         led_r   <= 8'd0;
         flag_r  <= 1'b0;
      end else begin
         cycle_r <= cycle_r + 32'd1;
         flag_r  <= flag_next_s;
         if (mmio_we_s && (sel_s == OFF_LED)) begin
            led_r <= WriteDataM[7:0];
         end
         if (mmio_we_s && (sel_s == OFF_CMP)) begin
            cmp_r <= WriteDataM;
         end
      end
   end

   // Word RAM, contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         mem_r[idx_s] <= WriteDataM;
      end
   end

   tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (8)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (WriteDataM[7:0]),
      .pop       (pop_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s),
      .head      (head_s)
   );

   // STATUS word assembly
   always_comb begin
      status_s             = 32'd0;
      status_s[STAT_MATCH] = flag_r;
      status_s[STAT_FULL]  = full_s;
      status_s[STAT_EMPTY] = empty_s;
   end

   // Zero-latency load mux
   always_comb begin
      rdata_s = 32'd0;
      case (region_s)
         REG_RAM: rdata_s = mem_r[idx_s];
         REG_MMIO: begin
            case (sel_s)
               OFF_LED:    rdata_s = {24'd0, led_r};
               OFF_CYCLE:  rdata_s = cycle_r;
               OFF_CMP:    rdata_s = cmp_r;
               OFF_STATUS: rdata_s = status_s;
               OFF_TXDATA: rdata_s = {{(32-CW){1'b0}}, count_s};
               default:    rdata_s = 32'd0;
            endcase
         end
         default: rdata_s = 32'd0;
      endcase
   end

   assign ReadDataM = rdata_s;
   assign led       = led_r;
   assign timer_irq = flag_r;
   assign tx_valid  = !empty_s;
   assign tx_data   = head_s;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Self-checking bench for dmem_mmio_unit: directed scenarios plus random traffic
// checked against a behavioural model built from the address map rules.
module tb_dmem_mmio_unit;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          FD    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ALUResultM = 32'd0;
   logic [31:0] WriteDataM = 32'd0;
   logic        MemWriteM = 1'b0;
   logic        tx_ready = 1'b0;
   logic [31:0] ReadDataM;
   logic [7:0]  led;
   logic        timer_irq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        fault;

   int total = 0;
   int bad = 0;

   // behavioural model state
   logic [31:0] m_ram [DEPTH];
   bit          m_wr [DEPTH];
   logic [7:0]  m_led;
   logic [31:0] m_cycle;
   logic [31:0] m_cmp;
   bit          m_flag;
   bit          m_fault;
   byte unsigned m_q[$];

   dmem_mmio_unit #(.DEPTH(DEPTH), .MMIO_BASE(BASE), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .ReadDataM(ReadDataM), .led(led), .timer_irq(timer_irq),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .fault(fault));

   always #5 clk = ~clk;

   // 0 = RAM, 1 = MMIO page, 2 = unmapped
   function automatic int region_of(input logic [31:0] a);
      if (a < 32'(DEPTH * 4)) return 0;
      if ((a >> 12) == (BASE >> 12)) return 1;
      return 2;
   endfunction

   function automatic int reg_of(input logic [31:0] a);
      return int'((a % 32'd32) / 32'd4);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (region_of(a) == 0) return m_ram[a / 32'd4];
      if (region_of(a) == 2) return 32'd0;
      case (reg_of(a))
         0: return {24'd0, m_led};
         1: return m_cycle;
         2: return m_cmp;
         3: return {29'd0, m_q.size() == 0, m_q.size() == FD, m_flag};
         4: return 32'(m_q.size());
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_fault_of(input logic [31:0] a, input logic we);
`ifdef DMEM_FAULT_EN
      return (a % 32'd4 != 32'd0) || region_of(a) == 2 ||
             (we && region_of(a) == 1 && reg_of(a) == 1);
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_reset();
      m_led = 8'd0; m_cycle = 32'd0; m_cmp = 32'd0; m_flag = 1'b0; m_fault = 1'b0;
      m_q.delete();
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
      ALUResultM = a; WriteDataM = d; MemWriteM = we; tx_ready = rdy;
      @(negedge clk);
   endtask

   // one rising edge: model consumes the inputs currently applied
   task automatic tick();
      bit f, commit, set, clr, pop, push;
      @(posedge clk);
      f      = m_fault_of(ALUResultM, MemWriteM);
      commit = MemWriteM && !f;
      set    = (m_cycle == m_cmp) && (m_cmp != 32'd0);
      clr    = commit && region_of(ALUResultM) == 1 && reg_of(ALUResultM) == 3 && WriteDataM[0];
      pop    = (m_q.size() > 0) && tx_ready;
      push   = commit && region_of(ALUResultM) == 1 && reg_of(ALUResultM) == 4;
      if (commit && region_of(ALUResultM) == 0) begin
         m_ram[ALUResultM / 32'd4] = WriteDataM;
         m_wr[ALUResultM / 32'd4] = 1'b1;
      end
      if (commit && region_of(ALUResultM) == 1 && reg_of(ALUResultM) == 0) m_led = WriteDataM[7:0];
      if (commit && region_of(ALUResultM) == 1 && reg_of(ALUResultM) == 2) m_cmp = WriteDataM;
      m_flag = set || (m_flag && !clr);
      if (pop) void'(m_q.pop_front());
      if (push && m_q.size() < FD) m_q.push_back(WriteDataM[7:0]);
      m_cycle = m_cycle + 32'd1;
      m_fault = f;
      #1;
   endtask

   task automatic do_reset();
      ALUResultM = 32'd0; WriteDataM = 32'd0; MemWriteM = 1'b0; tx_ready = 1'b0;
      reset = 1'b0;
      #1;
      m_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ALUResultM = BASE + 32'h4;
      #1;
      m_reset();
      total += 6;
      if (led !== 8'd0) begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      if (tx_data !== 8'd0) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
      if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
      if (ReadDataM !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%h exp=0", ReadDataM); end
      @(negedge clk);
      reset = 1'b1;
      ALUResultM = 32'd0;
      tick();
      apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'd1) begin bad++; $display("FAIL reset_first_count got=%h exp=1", ReadDataM); end
      tick();
   endtask

   task automatic test_ram();
      apply(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0); tick();
      apply(32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_10 got=%h exp=deadbeef", ReadDataM); end
      tick();
      apply(32'h14, 32'h1, 1'b1, 1'b0); tick();
      apply(32'h14, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'h1) begin bad++; $display("FAIL ram_14 got=%h exp=1", ReadDataM); end
      tick();
      apply(32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_10_kept got=%h exp=deadbeef", ReadDataM); end
      tick();
   endtask

   task automatic test_cycle();
      logic [31:0] c0, c1;
      apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
      c0 = ReadDataM;
      total++;
      if (c0 !== m_cycle) begin bad++; $display("FAIL cycle_a got=%h exp=%h", c0, m_cycle); end
      tick();
      for (int i = 0; i < 4; i++) begin apply(32'd0, 32'd0, 1'b0, 1'b0); tick(); end
      apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
      c1 = ReadDataM;
      total += 2;
      if (c1 - c0 !== 32'd5) begin bad++; $display("FAIL cycle_delta got=%0d exp=5", c1 - c0); end
      if (c1 !== m_cycle) begin bad++; $display("FAIL cycle_b got=%h exp=%h", c1, m_cycle); end
      tick();
      apply(BASE + 32'h4, 32'h0, 1'b1, 1'b0); tick();
      apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== m_cycle) begin bad++; $display("FAIL cycle_ro got=%h exp=%h", ReadDataM, m_cycle); end
      tick();
   endtask

   task automatic test_timer();
      int rise;
      do_reset();
      apply(BASE + 32'h8, 32'd20, 1'b1, 1'b0); tick();
      rise = -1;
      for (int i = 0; i < 40 && rise < 0; i++) begin
         apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
         total++;
         if (timer_irq !== m_flag) begin bad++; $display("FAIL timer_wait got=%b exp=%b", timer_irq, m_flag); end
         if (timer_irq === 1'b1) rise = int'(ReadDataM);
         tick();
      end
      total++;
      if (rise != 21) begin bad++; $display("FAIL timer_rise got=%0d exp=21", rise); end
      apply(BASE + 32'hC, 32'd1, 1'b1, 1'b0); tick();
      apply(32'd0, 32'd0, 1'b0, 1'b0);
      total++;
      if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_w1c got=%b exp=0", timer_irq); end
      tick();
      apply(BASE + 32'h8, 32'd0, 1'b1, 1'b0); tick();
      for (int i = 0; i < 30; i++) begin
         apply(BASE + 32'h4, 32'd0, 1'b0, 1'b0);
         total++;
         if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_cmp0 got=%b exp=0", timer_irq); end
         tick();
      end
   endtask

   task automatic test_fifo();
      for (int i = 0; i < 5; i++) begin apply(BASE + 32'h10, 32'h41 + 32'(i), 1'b1, 1'b0); tick(); end
      apply(BASE + 32'hC, 32'd0, 1'b0, 1'b0);
      total += 2;
      if (ReadDataM[1] !== 1'b1) begin bad++; $display("FAIL fifo_full_bit got=%b exp=1", ReadDataM[1]); end
      if (ReadDataM !== m_read(BASE + 32'hC)) begin bad++; $display("FAIL fifo_status got=%h exp=%h", ReadDataM, m_read(BASE + 32'hC)); end
      tick();
      apply(BASE + 32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'd4) begin bad++; $display("FAIL fifo_count got=%0d exp=4", ReadDataM); end
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(32'd0, 32'd0, 1'b0, 1'b1);
         total += 2;
         if (tx_valid !== 1'b1) begin bad++; $display("FAIL fifo_drain_valid got=%b exp=1", tx_valid); end
         if (tx_data !== 8'(8'h41 + i)) begin bad++; $display("FAIL fifo_drain_data got=%h exp=%h", tx_data, 8'(8'h41 + i)); end
         tick();
      end
      apply(32'd0, 32'd0, 1'b0, 1'b0);
      total += 2;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty_valid got=%b exp=0", tx_valid); end
      if (tx_data !== 8'd0) begin bad++; $display("FAIL fifo_empty_data got=%h exp=00", tx_data); end
      tick();
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h62; exp_b[1] = 8'h63; exp_b[2] = 8'h64; exp_b[3] = 8'h55;
      for (int i = 0; i < 4; i++) begin apply(BASE + 32'h10, 32'h61 + 32'(i), 1'b1, 1'b0); tick(); end
      apply(BASE + 32'h10, 32'h55, 1'b1, 1'b1);
      total++;
      if (tx_data !== 8'h61) begin bad++; $display("FAIL fpp_head got=%h exp=61", tx_data); end
      tick();
      apply(BASE + 32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'd4) begin bad++; $display("FAIL fpp_count got=%0d exp=4", ReadDataM); end
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(32'd0, 32'd0, 1'b0, 1'b1);
         total++;
         if (tx_data !== exp_b[i] || tx_valid !== 1'b1) begin
            bad++; $display("FAIL fpp_order idx=%0d got=%h/%b exp=%h/1", i, tx_data, tx_valid, exp_b[i]);
         end
         tick();
      end
   endtask

   task automatic test_fault();
      apply(32'h10, 32'h1234_5678, 1'b1, 1'b0); tick();
      apply(32'h13, 32'hCAFE_F00D, 1'b1, 1'b0); tick();
      apply(32'h10, 32'd0, 1'b0, 1'b0);
      total += 2;
`ifdef DMEM_FAULT_EN
      if (fault !== 1'b1) begin bad++; $display("FAIL fault_misaligned got=%b exp=1", fault); end
      if (ReadDataM !== 32'h1234_5678) begin bad++; $display("FAIL fault_suppress got=%h exp=12345678", ReadDataM); end
`else
      if (fault !== 1'b0) begin bad++; $display("FAIL fault_off got=%b exp=0", fault); end
      if (ReadDataM !== 32'hCAFE_F00D) begin bad++; $display("FAIL fault_truncate got=%h exp=cafef00d", ReadDataM); end
`endif
      tick();
      apply(32'h8000_0000, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", ReadDataM); end
      tick();
      apply(32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (fault !== m_fault) begin bad++; $display("FAIL fault_unmapped got=%b exp=%b", fault, m_fault); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, d, exp;
      logic we, rdy;
      bit known;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0, 1:    a = 32'($urandom_range(0, 15)) * 32'd4;
            2:       a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
            3: begin
               case ($urandom_range(0, 3))
                  0: a = 32'h400;
                  1: a = 32'h2000;
                  2: a = 32'h8000_0000;
                  default: a = 32'hFFFF_FFFC;
               endcase
            end
            default: a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
         endcase
         d = $urandom;
         if (region_of(a) == 1 && reg_of(a) == 2) d = m_cycle + 32'($urandom_range(1, 12));
         we  = 1'($urandom_range(0, 1));
         rdy = 1'($urandom_range(0, 1));
         apply(a, d, we, rdy);
         known = (region_of(a) != 0) || m_wr[a / 32'd4];
         exp = m_read(a);
         total += 5;
         if (known && ReadDataM !== exp) begin bad++; $display("FAIL rnd_read n=%0d a=%h got=%h exp=%h", n, a, ReadDataM, exp); end
         if (led !== m_led) begin bad++; $display("FAIL rnd_led n=%0d got=%h exp=%h", n, led, m_led); end
         if (timer_irq !== m_flag) begin bad++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, timer_irq, m_flag); end
         if (tx_valid !== (m_q.size() > 0) || tx_data !== ((m_q.size() > 0) ? m_q[0] : 8'd0)) begin
            bad++; $display("FAIL rnd_tx n=%0d got=%b/%h qsize=%0d", n, tx_valid, tx_data, m_q.size());
         end
         if (fault !== m_fault) begin bad++; $display("FAIL rnd_fault n=%0d got=%b exp=%b", n, fault, m_fault); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      apply(BASE, 32'hA5, 1'b1, 1'b0); tick();
      for (int i = 0; i < 3; i++) begin apply(BASE + 32'h10, 32'h71 + 32'(i), 1'b1, 1'b0); tick(); end
      apply(32'd0, 32'd0, 1'b0, 1'b1); tick();
      reset = 1'b0;
      #1;
      total += 3;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", tx_valid); end
      if (led !== 8'd0) begin bad++; $display("FAIL midrst_led got=%h exp=00", led); end
      if (tx_data !== 8'd0) begin bad++; $display("FAIL midrst_data got=%h exp=00", tx_data); end
      m_reset();
      @(negedge clk);
      reset = 1'b1;
      ALUResultM = 32'd0; MemWriteM = 1'b0; tx_ready = 1'b0;
      tick();
      apply(32'h10, 32'd0, 1'b0, 1'b0);
      total++;
      if (ReadDataM !== m_ram[4]) begin bad++; $display("FAIL midrst_ram got=%h exp=%h", ReadDataM, m_ram[4]); end
      tick();
   endtask

   initial begin
      test_reset();
      test_ram();
      test_cycle();
      test_timer();
      test_fifo();
      test_full_push_pop();
      test_fault();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
